// File: rtl/fir_ctrl_regs_pkg.sv
// fir_ctrl_pkg: register addresses and field widths shared by the FIR control block and its bench
package fir_ctrl_pkg;
  localparam int DATA_W   = 16;
  localparam int WSP_W    = 6;
  localparam int PROBEK_W = 14;
  localparam logic [2:0] ADDR_START      = 3'd0;
  localparam logic [2:0] ADDR_DONE       = 3'd1;
  localparam logic [2:0] ADDR_PRACUJE    = 3'd2;
  localparam logic [2:0] ADDR_ILE_WSP    = 3'd3;
  localparam logic [2:0] ADDR_ILE_PROBEK = 3'd4;
endpackage

// File: rtl/fir_ctrl_regs.sv
// fir_ctrl_regs: start command, filter configuration and status read mux for the FIR engine
module fir_ctrl_regs
  import fir_ctrl_pkg::*;
(
  input  logic                clk_b,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   CDC_data,
  input  logic [2:0]          nr_Rejestru,
  input  logic                wr_Rej,
  input  logic                Pracuje,
  input  logic                DONE,
  output logic [DATA_W-1:0]   Rej_out,
  output logic                Start,
  output logic [WSP_W-1:0]    Ile_wsp,
  output logic [PROBEK_W-1:0] Ile_probek
);
  logic                start_q, start_d;
  logic [WSP_W-1:0]    wsp_q, wsp_d;
  logic [PROBEK_W-1:0] probek_q, probek_d;
  logic                wr_ok;
  // every write is blocked while the engine runs, keeping configuration stable
  assign wr_ok = wr_Rej && !Pracuje;
  always_comb begin
    start_d  = wr_ok && nr_Rejestru == ADDR_START && CDC_data[0];
    wsp_d    = (wr_ok && nr_Rejestru == ADDR_ILE_WSP) ? CDC_data[WSP_W-1:0] : wsp_q;
    probek_d = (wr_ok && nr_Rejestru == ADDR_ILE_PROBEK) ? CDC_data[PROBEK_W-1:0] : probek_q;
  end
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      wsp_q    <= '0;
      probek_q <= '0;
    end else begin
      start_q  <= start_d;
      wsp_q    <= wsp_d;
      probek_q <= probek_d;
    end
  end
  always_comb begin
    Rej_out = (nr_Rejestru == ADDR_START)      ? {{(DATA_W-1){1'b0}}, start_q} :
              (nr_Rejestru == ADDR_DONE)       ? {{(DATA_W-1){1'b0}}, DONE} :
              (nr_Rejestru == ADDR_PRACUJE)    ? {{(DATA_W-1){1'b0}}, Pracuje} :
              (nr_Rejestru == ADDR_ILE_WSP)    ? {{(DATA_W-WSP_W){1'b0}}, wsp_q} :
              (nr_Rejestru == ADDR_ILE_PROBEK) ? {{(DATA_W-PROBEK_W){1'b0}}, probek_q} :
                                                 '0;
  end
  assign Start      = start_q;
  assign Ile_wsp    = wsp_q;
  assign Ile_probek = probek_q;
endmodule

// File: tb/tb_fir_ctrl_regs.sv
// tb_fir_ctrl_regs: directed scoreboard bench for the FIR control/status register bank
module tb_fir_ctrl_regs;
  import fir_ctrl_pkg::*;
  logic                clk_b = 1'b0;
  logic                rst_n;
  logic [DATA_W-1:0]   CDC_data;
  logic [2:0]          nr_Rejestru;
  logic                wr_Rej;
  logic                Pracuje;
  logic                DONE;
  logic [DATA_W-1:0]   Rej_out;
  logic                Start;
  logic [WSP_W-1:0]    Ile_wsp;
  logic [PROBEK_W-1:0] Ile_probek;
  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  fir_ctrl_regs dut (
    .clk_b(clk_b), .rst_n(rst_n), .CDC_data(CDC_data), .nr_Rejestru(nr_Rejestru),
    .wr_Rej(wr_Rej), .Pracuje(Pracuje), .DONE(DONE), .Rej_out(Rej_out),
    .Start(Start), .Ile_wsp(Ile_wsp), .Ile_probek(Ile_probek)
  );
  always #5 clk_b = ~clk_b;
  task automatic push(input string tag, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask
  task automatic chk(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: got %h, no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk_b);
    nr_Rejestru = a;
    CDC_data    = d;
    wr_Rej      = 1'b1;
    @(posedge clk_b);
    #1;
    wr_Rej = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a);
    nr_Rejestru = a;
    #1;
    chk(Rej_out);
  endtask
  initial begin
    rst_n = 1'b0; CDC_data = '0; nr_Rejestru = '0; wr_Rej = 1'b0; Pracuje = 1'b0; DONE = 1'b0;
    repeat (2) @(posedge clk_b);
    #1;
    push("rst_start", 16'h0);       chk({15'b0, Start});
    push("rst_wsp", 16'h0);         chk({10'b0, Ile_wsp});
    push("rst_probek", 16'h0);      chk({2'b0, Ile_probek});
    push("rst_rd0", 16'h0);         rd(3'd0);
    push("rst_rd3", 16'h0);         rd(3'd3);
    push("rst_rd4", 16'h0);         rd(3'd4);
    @(negedge clk_b);
    rst_n = 1'b1;
    push("start_pulse", 16'h1);
    push("start_rd0", 16'h1);
    wr(3'd0, 16'h0001);
    chk({15'b0, Start});
    chk(Rej_out);
    push("start_clear", 16'h0);
    @(posedge clk_b); #1;
    chk({15'b0, Start});
    Pracuje = 1'b1;
    push("start_busy", 16'h0);
    wr(3'd0, 16'h0001);
    chk({15'b0, Start});
    Pracuje = 1'b0;
    push("start_bit0_zero", 16'h0);
    wr(3'd0, 16'hFFFE);
    chk({15'b0, Start});
    push("wsp_45", 16'd45);
    wr(3'd3, 16'd45);
    chk({10'b0, Ile_wsp});
    push("rd_wsp", 16'h002D);       rd(3'd3);
    push("probek_1024", 16'd1024);
    wr(3'd4, 16'd1024);
    chk({2'b0, Ile_probek});
    push("rd_probek", 16'h0400);    rd(3'd4);
    push("wsp_trunc", 16'd63);
    wr(3'd3, 16'hFFFF);
    chk({10'b0, Ile_wsp});
    push("probek_trunc", 16'h3FFF);
    wr(3'd4, 16'hFFFF);
    chk({2'b0, Ile_probek});
    push("probek_1024b", 16'd1024);
    wr(3'd4, 16'd1024);
    chk({2'b0, Ile_probek});
    Pracuje = 1'b1; DONE = 1'b1;
    push("rd_done1", 16'h0001);     rd(3'd1);
    push("rd_pracuje1", 16'h0001);  rd(3'd2);
    DONE = 1'b0;
    push("rd_done0", 16'h0000);     rd(3'd1);
    push("wsp_protect", 16'd63);
    wr(3'd3, 16'd7);
    chk({10'b0, Ile_wsp});
    push("probek_protect", 16'd1024);
    wr(3'd4, 16'd5);
    chk({2'b0, Ile_probek});
    Pracuje = 1'b0;
    push("rd_pracuje0", 16'h0000);  rd(3'd2);
    push("rsvd_wsp", 16'd63);
    push("rsvd_probek", 16'd1024);
    push("rsvd_start", 16'h0);
    wr(3'd6, 16'hFFFF);
    chk({10'b0, Ile_wsp});
    chk({2'b0, Ile_probek});
    chk({15'b0, Start});
    push("rd_rsvd6", 16'h0);        rd(3'd6);
    push("rd_rsvd7", 16'h0);        rd(3'd7);
    push("wr_addr1_ignored", 16'h0);
    wr(3'd1, 16'hFFFF);
    chk({15'b0, Start});
    @(negedge clk_b);
    nr_Rejestru = 3'd0; CDC_data = 16'h0001; wr_Rej = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("hold_start%0d", i), 16'h1);
      @(posedge clk_b); #1;
      chk({15'b0, Start});
    end
    wr_Rej = 1'b0;
    push("hold_clear", 16'h0);
    @(posedge clk_b); #1;
    chk({15'b0, Start});
    wr(3'd3, 16'd20);
    wr(3'd0, 16'h0001);
    push("pre_rst_start", 16'h1);   chk({15'b0, Start});
    #1;
    rst_n = 1'b0;
    #1;
    push("arst_start", 16'h0);      chk({15'b0, Start});
    push("arst_wsp", 16'h0);        chk({10'b0, Ile_wsp});
    push("arst_probek", 16'h0);     chk({2'b0, Ile_probek});
    push("arst_rd3", 16'h0);        rd(3'd3);
    push("arst_rd4", 16'h0);        rd(3'd4);
    if (sb.size() != 0) begin
      errors++;
      $error("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
